// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// ----------------
// Shares one SRAM-like slave bus between the instruction-fetch master and
// the data-access master of the CPU core. Each transaction runs as
// accept (IDLE) -> address handshake (ADDR) -> data handshake (DATA).
// Only one transaction is outstanding at a time. The response goes back
// to the master that won the grant.
//
// Configuration macro: SRAM_ARB_RR_EN
//   undefined : fixed priority, the data master always wins contention.
//   defined   : round-robin. A last_owner register records the most recent
//               grant, and on contention the other master wins.
//
// Ports
//   clk, resetn                  core clock, synchronous active-low reset
//   inst_* / data_* (inputs)     master request: req, wr, size, wstrb,
//                                addr, wdata
//   inst_* / data_* (outputs)    addr_ok (accepted this cycle),
//                                data_ok (response valid this cycle),
//                                rdata (valid with data_ok)
//   req, wr, size, wstrb,
//   addr, wdata (outputs)        slave request fields
//   addr_ok, data_ok, rdata      slave handshakes and read data

module sram_bus_arbiter (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

`ifdef SRAM_ARB_RR_EN
  logic        last_owner_q, last_owner_d;
`endif

  logic        grant_data;
  logic        grant_inst;
  logic        resp_valid;

  // Arbitration. The data master wins unless round-robin is enabled and it
  // was the last one granted while the inst master is also requesting.
  always_comb begin
`ifdef SRAM_ARB_RR_EN
    grant_data = data_req & (~inst_req | ~last_owner_q);
`else
    grant_data = data_req;
`endif
    grant_inst = inst_req & ~grant_data;
  end

  // Next-state logic. The winner's fields are captured in IDLE so that the
  // slave sees stable values for however long ADDR lasts. A slave data_ok
  // outside DATA is a protocol error and is ignored.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef SRAM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = ADDR;
          owner_d = 1'b1;
          wr_d    = data_wr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          addr_d  = data_addr;
          wdata_d = data_wdata;
`ifdef SRAM_ARB_RR_EN
          last_owner_d = 1'b1;
`endif
        end else if (grant_inst) begin
          state_d = ADDR;
          owner_d = 1'b0;
          wr_d    = inst_wr;
          size_d  = inst_size;
          wstrb_d = inst_wstrb;
          addr_d  = inst_addr;
          wdata_d = inst_wdata;
`ifdef SRAM_ARB_RR_EN
          last_owner_d = 1'b0;
`endif
        end
      end
      ADDR: begin
        if (addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef SRAM_ARB_RR_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef SRAM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Master-facing outputs. The handshakes are held low while resetn is
  // asserted, because a grant made during reset would be discarded. The
  // rdata outputs are zero except in the cycle that their data_ok pulses.
  always_comb begin
    resp_valid   = resetn && (state_q == DATA) && data_ok;
    inst_addr_ok = resetn && (state_q == IDLE) && grant_inst;
    data_addr_ok = resetn && (state_q == IDLE) && grant_data;
    inst_data_ok = resp_valid && !owner_q;
    data_data_ok = resp_valid && owner_q;
    inst_rdata   = inst_data_ok ? rdata : 32'd0;
    data_rdata   = data_data_ok ? rdata : 32'd0;
  end

  // Slave-facing outputs come straight from the latched registers.
  always_comb begin
    req   = (state_q == ADDR);
    wr    = wr_q;
    size  = size_q;
    wstrb = wstrb_q;
    addr  = addr_q;
    wdata = wdata_q;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
// -------------------
// Directed bench for sram_bus_arbiter. The bench acts as both masters and
// as the slave. Inputs change 1 ns after each rising edge, and outputs are
// checked 2 ns later, well away from the next edge.

module tb_sram_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  sram_bus_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .wstrb        (wstrb),
    .addr         (addr),
    .wdata        (wdata),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle, then check them.
  task automatic settle();
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Run the linear sequence of directed steps.
  initial begin
    bit exp_data;
    int k;

    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'd0; data_wdata = 32'd0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;

    // Reset state. Requests and slave noise are present, but the outputs must stay quiet.
    tick();
    tick();
    inst_req = 1'b1; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    settle();
    check_output("rst_req", {31'd0, req}, 32'd0);
    check_output("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    check_output("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check_output("rst_rdata", inst_rdata | data_rdata, 32'd0);
    check_output("rst_addr", addr, 32'd0);
    tick();
    inst_req = 1'b0; data_ok = 1'b0; rdata = 32'd0;
    resetn = 1'b1;
    tick();

    // Test 1: single inst read.
    $display("[TB] single read");
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    settle();
    check_output("t1_c0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    check_output("t1_c0_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    check_output("t1_c0_req", {31'd0, req}, 32'd0);
    tick();
    inst_req = 1'b0; addr_ok = 1'b1;
    settle();
    check_output("t1_c1_req", {31'd0, req}, 32'd1);
    check_output("t1_c1_addr", addr, 32'h1C00_0000);
    check_output("t1_c1_wr", {31'd0, wr}, 32'd0);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0280_0C0C;
    settle();
    check_output("t1_c2_req", {31'd0, req}, 32'd0);
    check_output("t1_c2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_output("t1_c2_inst_rdata", inst_rdata, 32'h0280_0C0C);
    check_output("t1_c2_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick();
    data_ok = 1'b0; rdata = 32'd0;
    settle();
    check_output("t1_c3_idle_req", {31'd0, req}, 32'd0);
    check_output("t1_c3_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();

    // Test 2: both masters request for 9 cycles, and the slave acks at once.
    $display("[TB] contention");
    inst_req = 1'b1; inst_addr = 32'h0000_0100; inst_wr = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_0200; data_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      k = i / 3;
`ifdef SRAM_ARB_RR_EN
      exp_data = ((k % 2) == 0);
`else
      exp_data = 1'b1;
`endif
      addr_ok = (i % 3 == 1);
      data_ok = (i % 3 == 2);
      rdata   = 32'hA0 + i;
      settle();
      if (i % 3 == 0) begin
        check_output($sformatf("t2_c%0d_data_addr_ok", i), {31'd0, data_addr_ok}, {31'd0, exp_data});
        check_output($sformatf("t2_c%0d_inst_addr_ok", i), {31'd0, inst_addr_ok}, {31'd0, ~exp_data});
      end else if (i % 3 == 1) begin
        check_output($sformatf("t2_c%0d_req", i), {31'd0, req}, 32'd1);
        check_output($sformatf("t2_c%0d_addr", i), addr, exp_data ? 32'h200 : 32'h100);
        check_output($sformatf("t2_c%0d_wr", i), {31'd0, wr}, {31'd0, exp_data});
        check_output($sformatf("t2_c%0d_addr_oks", i), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      end else begin
        check_output($sformatf("t2_c%0d_data_data_ok", i), {31'd0, data_data_ok}, {31'd0, exp_data});
        check_output($sformatf("t2_c%0d_inst_data_ok", i), {31'd0, inst_data_ok}, {31'd0, ~exp_data});
        check_output($sformatf("t2_c%0d_rdata", i), exp_data ? data_rdata : inst_rdata, 32'hA0 + i);
      end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
    inst_wr = 1'b0; data_wr = 1'b0;

    // Test 3: byte store through a slow slave.
    $display("[TB] slow slave");
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
    data_addr = 32'h0000_0006; data_wdata = 32'h00AB_0000;
    settle();
    check_output("t3_grant", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; data_addr = 32'hDEAD_BEEF; data_wdata = 32'd0; data_wstrb = 4'hF;
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_output($sformatf("t3_w%0d_req", i), {31'd0, req}, 32'd1);
      check_output($sformatf("t3_w%0d_fields", i), {25'd0, wr, size, wstrb}, {25'd0, 1'b1, 2'd0, 4'b0100});
      check_output($sformatf("t3_w%0d_addr", i), addr, 32'h0000_0006);
      check_output($sformatf("t3_w%0d_wdata", i), wdata, 32'h00AB_0000);
      check_output($sformatf("t3_w%0d_inst_addr_ok", i), {31'd0, inst_addr_ok}, 32'd0);
      tick();
    end
    addr_ok = 1'b1;
    settle();
    check_output("t3_addr_req", {31'd0, req}, 32'd1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555_5555;
    settle();
    check_output("t3_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    check_output("t3_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    check_output("t3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_ok = 1'b0; rdata = 32'd0;

    // Test 4: an inst response is routed while a data request is pending.
    $display("[TB] response routing");
    settle();
    check_output("t4_inst_grant", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0000_0300;
    addr_ok = 1'b1;
    settle();
    check_output("t4_addr_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    check_output("t4_addr_addr", addr, 32'h1C00_0040);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678;
    settle();
    check_output("t4_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_output("t4_inst_rdata", inst_rdata, 32'h1234_5678);
    check_output("t4_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    check_output("t4_data_rdata", data_rdata, 32'd0);
    check_output("t4_data_addr_ok_in_data", {31'd0, data_addr_ok}, 32'd0);
    tick();
    data_ok = 1'b0; rdata = 32'd0;
    settle();
    check_output("t4_idle_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0;

    // Test 5: a spurious slave data_ok arrives while in ADDR.
    $display("[TB] spurious data_ok");
    data_ok = 1'b1; rdata = 32'h7777_7777;
    settle();
    check_output("t5_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check_output("t5_req", {31'd0, req}, 32'd1);
    tick();
    data_ok = 1'b0;
    settle();
    check_output("t5_still_addr", {31'd0, req}, 32'd1);
    check_output("t5_addr", addr, 32'h0000_0300);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;

    // Test 6: reset arrives in DATA, then an inst read follows.
    $display("[TB] reset mid-transaction");
    settle();
    check_output("t6_in_data_req", {31'd0, req}, 32'd0);
    resetn = 1'b0;
    tick();
    settle();
    check_output("t6_rst_req", {31'd0, req}, 32'd0);
    check_output("t6_rst_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    check_output("t6_rst_rdata", inst_rdata | data_rdata, 32'd0);
    check_output("t6_rst_addr", addr, 32'd0);
    tick();
    resetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0080; data_ok = 1'b1; rdata = 32'h9999_9999;
    settle();
    check_output("t6_idle_grant", {31'd0, inst_addr_ok}, 32'd1);
    check_output("t6_idle_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    tick();
    inst_req = 1'b0; data_ok = 1'b0; addr_ok = 1'b1;
    settle();
    check_output("t6_addr", addr, 32'h1C00_0080);
    check_output("t6_req", {31'd0, req}, 32'd1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    settle();
    check_output("t6_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_output("t6_inst_rdata", inst_rdata, 32'hCAFE_F00D);
    tick();
    data_ok = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
